// File: rtl/eth_pkg.sv
// eth_pkg: receive-path types and constants shared by the RMII unpacker.
package eth_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, DEST_ADDR, SRC_ADDR, LENGTH, PAYLOAD, DROP} rx_state_t;
    localparam int ADDR_DIBITS = 24;
    localparam int LEN_DIBITS = 8;
    localparam int FCS_DIBITS = 16;
    localparam logic [47:0] BCAST_ADDR = '1;
    function automatic logic [47:0] wire_order(input logic [47:0] a);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) r[8*i +: 8] = a[8*(5-i) +: 8];
        return r;
    endfunction
endpackage

// File: rtl/crc32.sv
// crc32: Ethernet CRC-32 over a dibit stream, bits consumed LSB-first.
module crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic [31:0] axiod
);
    logic [31:0] c, s1, s2;
    always_comb begin
        s1 = {1'b0, c[31:1]} ^ ((c[0] ^ axiid[0]) ? 32'hEDB88320 : 32'h0);
        s2 = {1'b0, s1[31:1]} ^ ((s1[0] ^ axiid[1]) ? 32'hEDB88320 : 32'h0);
        for (int i = 0; i < 32; i++) axiod[i] = ~c[31-i];
    end
    always_ff @(posedge clk) c <= rst ? 32'hFFFFFFFF : axiiv ? s2 : c;
endmodule

// File: rtl/eth_unpacker.sv
// eth_unpacker: RMII receive deframer; filters on destination, strips header,
// hides the FCS behind a 16-dibit delay line and reports FCS/alignment status.
module eth_unpacker import eth_pkg::*; #(
    parameter logic [47:0] MY_ADDR     = 48'h000000000000,
    parameter int          PRE_MIN     = 8,
    parameter int          MAX_DIBITS  = 6072,
    parameter logic [31:0] CRC_RESIDUE = 32'h38FB2284
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phy_crsdv,
    input  logic [1:0]  phy_rxd,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic [15:0] length,
    output logic        frame_done,
    output logic        frame_ok
);
    rx_state_t state, state_n;
    logic [4:0] pre_cnt, fill;
    logic [12:0] cnt;
    logic [47:0] addr, addr_n;
    logic [15:0] len_sr;
    logic [31:0] dline, crc;
    logic sfd, rx_frame, too_long, addr_hit;

    assign rx_frame = state inside {DEST_ADDR, SRC_ADDR, LENGTH, PAYLOAD};
    assign sfd = state == PREAMBLE && phy_crsdv && phy_rxd == 2'b11 && 32'(pre_cnt) >= PRE_MIN;
    assign too_long = rx_frame && phy_crsdv && cnt == 13'(MAX_DIBITS);
    assign length = {len_sr[7:0], len_sr[15:8]};

    crc32 u_crc (.clk(clk), .rst(rst || sfd), .axiiv(rx_frame && phy_crsdv), .axiid(phy_rxd), .axiod(crc));

    // One post-SFD dibit counter drives both field boundaries and the size limit.
    always_comb begin
        addr_n = {phy_rxd, addr[47:2]};
        addr_hit = addr_n == wire_order(MY_ADDR) || addr_n == BCAST_ADDR;
        state_n = state;
        if (!phy_crsdv) state_n = IDLE;
        else if (too_long) state_n = DROP;
        else case (state)
            IDLE:      state_n = phy_rxd == 2'b01 ? PREAMBLE : IDLE;
            PREAMBLE:  state_n = sfd ? DEST_ADDR : phy_rxd == 2'b01 ? PREAMBLE : IDLE;
            DEST_ADDR: state_n = cnt == 13'(ADDR_DIBITS - 1) ? (addr_hit ? SRC_ADDR : DROP) : state;
            SRC_ADDR:  state_n = cnt == 13'(2*ADDR_DIBITS - 1) ? LENGTH : state;
            LENGTH:    state_n = cnt == 13'(2*ADDR_DIBITS + LEN_DIBITS - 1) ? PAYLOAD : state;
            default:   state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pre_cnt <= '0;
            cnt <= '0;
            fill <= '0;
            addr <= '0;
            len_sr <= '0;
            dline <= '0;
            axiov <= 1'b0;
            axiod <= 2'b00;
            frame_done <= 1'b0;
            frame_ok <= 1'b0;
        end else begin
            state <= state_n;
            axiov <= 1'b0;
            frame_done <= 1'b0;
            frame_ok <= 1'b0;
            pre_cnt <= state == PREAMBLE ? pre_cnt + 5'(pre_cnt != 5'd31) : 5'd1;
            cnt <= sfd ? '0 : cnt + 13'(rx_frame);
            if (sfd) fill <= '0;
            if (state == DEST_ADDR) addr <= addr_n;
            if (state == LENGTH) len_sr <= {phy_rxd, len_sr[15:2]};
            if (state == PAYLOAD && phy_crsdv && !too_long) begin
                dline <= {dline[29:0], phy_rxd};
                if (fill == 5'(FCS_DIBITS)) begin
                    axiov <= 1'b1;
                    axiod <= dline[31:30];
                end else fill <= fill + 5'd1;
            end
            if (rx_frame && !phy_crsdv) begin
                frame_done <= 1'b1;
                frame_ok <= state == PAYLOAD && crc == CRC_RESIDUE && cnt[1:0] == 2'b00 && fill == 5'(FCS_DIBITS);
            end
        end
    end
endmodule

// File: doc/eth_unpacker.md
# eth_unpacker

Receive-side counterpart of the Ethernet TX packer on FPGA2. Samples RMII dibits from the PHY, finds the preamble/SFD and checks the destination address. Strips the 14-byte header, checks the FCS with the shared `crc32` module, and forwards payload dibits downstream on a valid/data stream. The FCS is held back in a 16-dibit delay line so it never reaches the consumer.

## Interface
Parameters:
- `MY_ADDR`, 48'h000000000000: accepted unicast destination; broadcast (all ones) is always accepted.
- `PRE_MIN`, 8: minimum count of 2'b01 preamble dibits before the SFD.
- `MAX_DIBITS`, 6072: maximum dibits from destination through FCS (1518 bytes).
- `CRC_RESIDUE`, 32'h38FB2284: `crc32` output after the FCS of a valid frame.

Ports:
- `clk`, in, 1: 50 MHz RMII reference clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `phy_crsdv`, in, 1: RMII carrier-sense/data-valid.
- `phy_rxd`, in, 2: RMII receive dibit, LSB-first within each byte.
- `axiov`, out, 1: payload dibit valid.
- `axiod`, out, 2: payload dibit, in wire order.
- `length`, out, 16: length/type field, valid while `frame_done` is high.
- `frame_done`, out, 1: 1-cycle pulse at end of an accepted frame.
- `frame_ok`, out, 1: qualifies `frame_done`; 1 means FCS matched and the frame is well formed.

## Operation
- States: Idle, Preamble, DestAddr, SrcAddr, Length, Payload, Drop.
- **Idle**
  - `phy_crsdv`=1 with `phy_rxd`=01 → Preamble, preamble count=1.
  - Anything else stays in Idle.
- **Preamble**
  - 01 increments the count, saturating at 31.
  - 11 with count ≥ `PRE_MIN` → DestAddr; resets `crc32` and the dibit counter.
  - 11 with count < `PRE_MIN`, any other dibit, or `phy_crsdv`=0 → Idle, no pulse.
- **CRC feed.** Every dibit sampled in DestAddr, SrcAddr, Length and Payload is fed to `crc32`.
- **DestAddr (24 dibits).**
  - Dibits are shifted into a 48-bit register, LSB-first.
  - On the 24th dibit the address is compared against `MY_ADDR` and all-ones.
  - Match → SrcAddr. Mismatch → Drop.
- **SrcAddr (24 dibits).** Contents are discarded. Then → Length.
- **Length (8 dibits).**
  - First byte is the MSB byte; bits within each byte arrive LSB-first.
  - Captured into `length`. Then → Payload.
- **Payload.** Each sampled dibit is pushed into a 16-entry dibit delay line.
  - A push that finds the line full emits the oldest entry: on the next edge, `axiov`<=1 and `axiod`<=oldest.
  - On all other cycles `axiov`<=0.
- **End of frame.** `phy_crsdv`=0 in Payload → Idle, and on the next edge `frame_done`<=1. The 16 entries still held in the delay line are the FCS and are discarded.
- **`frame_ok`.** Set to 1 only if all of the following hold:
  - `crc32` output == `CRC_RESIDUE`;
  - total dibits since the SFD is a multiple of 4;
  - the delay line held 16 entries (payload ≥ 0 bytes plus FCS).
- **Drop.** Ignores input. `phy_crsdv`=0 → Idle, no pulse, `axiov` stays 0.
- **Length limit.** The dibit counter (13 bits) reaching `MAX_DIBITS` in any post-SFD state → Drop. Payload already emitted is not retracted; `frame_done` is not pulsed.
- **Runt.** `phy_crsdv`=0 in DestAddr, SrcAddr or Length → Idle with `frame_done`=1, `frame_ok`=0.
- **Reset values.**
  - State Idle; delay line emptied; counters 0.
  - `axiov`=0, `axiod`=0, `length`=0, `frame_done`=0, `frame_ok`=0.
  - `rst` mid-frame aborts immediately. The remainder of that frame is treated as a new frame attempt, so it must show a valid preamble to be accepted.

## Timing
- Inputs are sampled on every rising `clk` edge; no input registering beyond the FSM.
- Payload latency: payload dibit *i* appears on `axiod` in the cycle after the edge that samples payload dibit *i*+16.
- `axiov` has no backpressure; the consumer must accept every asserted cycle.
- `frame_done`/`frame_ok` are asserted exactly one cycle after the first sampled `phy_crsdv`=0. The last `axiov` occurs at or before that cycle.
- Back-to-back frames: from the Idle entered at `frame_done`, a new preamble is accepted on the very next edge.

## Structure
- `eth_pkg`:
  - receive state enum;
  - `ADDR_DIBITS`=24, `LEN_DIBITS`=8, `FCS_DIBITS`=16;
  - broadcast address constant.
- One sub-module: the existing `crc32`, instantiated unmodified and driven with `phy_rxd`. Its `rst` is asserted for the SFD cycle.
- The delay line is a 16×2-bit shift register with a 5-bit fill count, implemented inside this module.

## Test plan
- **Good broadcast frame.** 31×01 + 11, dest FF…FF, src 91:54:06:5A:69:69, length ABCD, 64-byte payload 00..3F, correct FCS.
  - Exactly 256 `axiov` cycles carrying the payload in order.
  - `length`=16'hABCD; `frame_done`=1 and `frame_ok`=1 one cycle after `phy_crsdv` falls.
- **Corrupted FCS.** Same frame with one payload bit flipped.
  - 256 `axiov` cycles; `frame_done`=1, `frame_ok`=0.
- **Address filter.** `MY_ADDR`=02:00:00:00:00:01, frame sent to 02:00:00:00:00:02.
  - No `axiov`, no `frame_done`.
  - A following frame to `MY_ADDR` is accepted with `frame_ok`=1.
- **Runt and alignment.**
  - `phy_crsdv` drops after 10 dest dibits → `frame_done`=1, `frame_ok`=0.
  - Good frame plus 1 extra dibit → `frame_ok`=0.
- **Short preamble, oversize, and reset.**
  - 4×01 + 11 → ignored.
  - 6100-dibit frame → Drop, no pulse.
  - `rst` asserted mid-Payload → all outputs 0 the next cycle; a following good frame gives `frame_ok`=1.
